// File: rtl/zbuf_mem_sched.sv
// ---------------------------------------------------------------------------
// zbuf_mem_sched
//
// Purpose:
//   Arbitrates the single z-buffer memory port between three sources:
//   depth-test reads, depth-test writebacks and a full-buffer clear engine.
//   One access is in flight at a time. A read's fragment tag stays attached
//   to its returned data. A frame clear waits for the in-flight transaction
//   to finish and never drops a request that has already been accepted.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   clear_req         one-cycle pulse that requests a buffer clear
//   clear_busy        a clear is pending or running
//   rd_nd/rd_us_rfd   read request handshake (rd_addr, rd_tag)
//   rd_rdy/ds_rfd     read return handshake (rd_data, rd_tag_out)
//   wr_nd/wr_us_rfd   write request handshake (wr_addr, wr_data)
//   mem_*             memory controller port: req/we/addr/wdata out;
//                     gnt/rvalid/rdata in
// ---------------------------------------------------------------------------
module zbuf_mem_sched #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 16,
    parameter int                TAG_W       = 19,
    parameter int                CLEAR_WORDS = 307200,
    parameter logic [DATA_W-1:0] CLEAR_VAL   = 'h7BFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              rd_nd,
    output logic              rd_us_rfd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_rdy,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag_out,
    input  logic              ds_rfd,
    input  logic              wr_nd,
    output logic              wr_us_rfd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W    = (CLEAR_WORDS > 1) ? $clog2(CLEAR_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        RET_RD  = 3'd3,
        CLEAR   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              clr_pend_q, clr_pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_full_q, rd_full_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [TAG_W-1:0]  rd_tag_q, rd_tag_d;
    logic              wr_full_q, wr_full_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rfd_q, rfd_d;
    logic              rd_rdy_q, rd_rdy_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [TAG_W-1:0]  rd_tag_out_q, rd_tag_out_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic rd_acc, wr_acc;

    // Both sources share one ready flag: either may be taken only when
    // the scheduler is idle, no clear is pending and no entry is held.
    assign rd_acc = rd_nd & rfd_q;
    assign wr_acc = wr_nd & rfd_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so that no
        // path leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        clr_pend_d   = clr_pend_q | clear_req;  // a repeat request is a no-op
        cnt_d        = cnt_q;
        rd_full_d    = rd_full_q | rd_acc;
        rd_addr_d    = rd_acc ? rd_addr : rd_addr_q;
        rd_tag_d     = rd_acc ? rd_tag  : rd_tag_q;
        wr_full_d    = wr_full_q | wr_acc;
        wr_addr_d    = wr_acc ? wr_addr : wr_addr_q;
        wr_data_d    = wr_acc ? wr_data : wr_data_q;
        rd_rdy_d     = rd_rdy_q;
        rd_data_d    = rd_data_q;
        rd_tag_out_d = rd_tag_out_q;

        unique case (state_q)
            IDLE: begin
                if (clr_pend_d)                  state_d = CLEAR;
                else if (rd_full_d || wr_full_d) state_d = ISSUE;
            end
            ISSUE: begin
                if (mem_gnt) begin
                    if (wr_full_q) begin
                        // The write goes first, so a read to the same address
                        // sees the new depth. A pending clear outranks the
                        // held read, so in that case return to IDLE.
                        wr_full_d = 1'b0;
                        state_d   = (rd_full_q && !clr_pend_d) ? ISSUE : IDLE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    rd_data_d    = mem_rdata;
                    rd_tag_out_d = rd_tag_q;
                    rd_full_d    = 1'b0;
                    rd_rdy_d     = 1'b1;
                    state_d      = RET_RD;
                end
            end
            RET_RD: begin
                if (ds_rfd) begin
                    rd_rdy_d = 1'b0;
                    state_d  = clr_pend_d ? CLEAR : IDLE;
                end
            end
            CLEAR: begin
                if (mem_gnt) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        clr_pend_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Memory-port outputs are registered. They are derived from the next
        // state, so the request appears on the cycle the state is entered.
        mem_req_d   = (state_d == ISSUE) || (state_d == CLEAR);
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == CLEAR) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_W'(cnt_d);
            mem_wdata_d = CLEAR_VAL;
        end else if (state_d == ISSUE) begin
            if (wr_full_d) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr_d;
                mem_wdata_d = wr_data_d;
            end else begin
                mem_addr_d  = rd_addr_d;
            end
        end

        rfd_d = (state_d == IDLE) && !clr_pend_d && !rd_full_d && !wr_full_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            clr_pend_q   <= 1'b0;
            cnt_q        <= '0;
            // NOTE: the payload registers are reset along with the valid
            // flags. That keeps every output at zero in reset and costs
            // nothing here, because these are flops and not a memory array.
            rd_full_q    <= 1'b0;
            rd_addr_q    <= '0;
            rd_tag_q     <= '0;
            wr_full_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rfd_q        <= 1'b0;
            rd_rdy_q     <= 1'b0;
            rd_data_q    <= '0;
            rd_tag_out_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_pend_q   <= clr_pend_d;
            cnt_q        <= cnt_d;
            rd_full_q    <= rd_full_d;
            rd_addr_q    <= rd_addr_d;
            rd_tag_q     <= rd_tag_d;
            wr_full_q    <= wr_full_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rfd_q        <= rfd_d;
            rd_rdy_q     <= rd_rdy_d;
            rd_data_q    <= rd_data_d;
            rd_tag_out_q <= rd_tag_out_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign clear_busy = clr_pend_q;
    assign rd_us_rfd  = rfd_q;
    assign wr_us_rfd  = rfd_q;
    assign rd_rdy     = rd_rdy_q;
    assign rd_data    = rd_data_q;
    assign rd_tag_out = rd_tag_out_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_zbuf_mem_sched.sv
// ---------------------------------------------------------------------------
// tb_zbuf_mem_sched
//
// Directed bench for zbuf_mem_sched, with CLEAR_WORDS reduced to 4.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that
// same point, after the registered outputs have settled.
// ---------------------------------------------------------------------------
module tb_zbuf_mem_sched;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear_req;
    logic              clear_busy;
    logic              rd_nd;
    logic              rd_us_rfd;
    logic [ADDR_W-1:0] rd_addr;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_rdy;
    logic [DATA_W-1:0] rd_data;
    logic [TAG_W-1:0]  rd_tag_out;
    logic              ds_rfd;
    logic              wr_nd;
    logic              wr_us_rfd;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    zbuf_mem_sched #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TAG_W       (TAG_W),
        .CLEAR_WORDS (4),
        .CLEAR_VAL   (16'h7BFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .rd_nd      (rd_nd),
        .rd_us_rfd  (rd_us_rfd),
        .rd_addr    (rd_addr),
        .rd_tag     (rd_tag),
        .rd_rdy     (rd_rdy),
        .rd_data    (rd_data),
        .rd_tag_out (rd_tag_out),
        .ds_rfd     (ds_rfd),
        .wr_nd      (wr_nd),
        .wr_us_rfd  (wr_us_rfd),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks every memory-port output at once.
    task automatic check_mem(input string tag, input logic req, input logic we,
                             input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        check({tag, ".req"},   64'(mem_req),   64'(req));
        check({tag, ".we"},    64'(mem_we),    64'(we));
        check({tag, ".addr"},  64'(mem_addr),  64'(addr));
        check({tag, ".wdata"}, 64'(mem_wdata), 64'(wdata));
    endtask

    // Runs a 4-word clear with mem_gnt held high. The clear must already be
    // running, with its first request on the port.
    task automatic run_clear(input string tag);
        mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_mem($sformatf("%s.w%0d", tag, i), 1'b1, 1'b1, ADDR_W'(i), 16'h7BFF);
            check($sformatf("%s.busy%0d", tag, i), 64'(clear_busy), 64'd1);
            check($sformatf("%s.rfd%0d", tag, i), 64'(rd_us_rfd | wr_us_rfd), 64'd0);
            tick();
        end
        mem_gnt = 1'b0;
        check({tag, ".busy_end"}, 64'(clear_busy), 64'd0);
        check({tag, ".req_end"},  64'(mem_req),    64'd0);
        check({tag, ".rfd_end"},  64'(rd_us_rfd),  64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; clear_req = 1'b0; rd_nd = 1'b0; rd_addr = '0; rd_tag = '0;
        ds_rfd = 1'b0; wr_nd = 1'b0; wr_addr = '0; wr_data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // ---- 1. reset, then a single read --------------------------------
        tick(); tick();
        check_mem("rst", 1'b0, 1'b0, '0, '0);
        check("rst.rfd",  64'(rd_us_rfd | wr_us_rfd), 64'd0);
        check("rst.busy", 64'(clear_busy), 64'd0);
        check("rst.rdy",  64'(rd_rdy), 64'd0);
        rst = 1'b1;
        tick();
        check("idle.rd_rfd", 64'(rd_us_rfd), 64'd1);
        check("idle.wr_rfd", 64'(wr_us_rfd), 64'd1);

        // Assert reset while a request is live: outputs drop without a clock edge.
        rd_nd = 1'b1; rd_addr = 32'h1111;
        tick();
        rd_nd = 1'b0;
        check("pre_rst.req", 64'(mem_req), 64'd1);
        rst = 1'b0;
        #1;
        check_mem("async_rst", 1'b0, 1'b0, '0, '0);
        check("async_rst.rfd", 64'(rd_us_rfd), 64'd0);
        rst = 1'b1;
        tick();
        check("post_rst.rfd", 64'(rd_us_rfd), 64'd1);

        rd_nd = 1'b1; rd_addr = 32'h12C0; rd_tag = 19'h00A1;
        tick();
        rd_nd = 1'b0;
        check_mem("t1.issue", 1'b1, 1'b0, 32'h12C0, '0);
        check("t1.rfd", 64'(rd_us_rfd), 64'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("t1.wait_req", 64'(mem_req), 64'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'h3C00;
        tick();
        mem_rvalid = 1'b0;
        check("t1.rdy",  64'(rd_rdy),     64'd1);
        check("t1.data", 64'(rd_data),    64'h3C00);
        check("t1.tag",  64'(rd_tag_out), 64'h00A1);
        tick();
        check("t1.hold_rdy",  64'(rd_rdy),  64'd1);
        check("t1.hold_data", 64'(rd_data), 64'h3C00);
        ds_rfd = 1'b1;
        #1;
        check("t1.rdy_in_ds", 64'(rd_rdy), 64'd1);
        tick();
        ds_rfd = 1'b0;
        check("t1.rdy_drop", 64'(rd_rdy), 64'd0);
        check("t1.rfd_back", 64'(rd_us_rfd), 64'd1);

        // ---- 2. simultaneous write and read: the write goes first ---------
        wr_nd = 1'b1; wr_addr = 32'h5; wr_data = 16'h3800;
        rd_nd = 1'b1; rd_addr = 32'h5; rd_tag = 19'h7;
        tick();
        wr_nd = 1'b0; rd_nd = 1'b0;
        check_mem("t2.wr", 1'b1, 1'b1, 32'h5, 16'h3800);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_mem("t2.rd", 1'b1, 1'b0, 32'h5, '0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("t2.wait_req", 64'(mem_req), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_rvalid = 1'b0;
        check("t2.rdy",  64'(rd_rdy),     64'd1);
        check("t2.data", 64'(rd_data),    64'h1234);
        check("t2.tag",  64'(rd_tag_out), 64'h7);
        ds_rfd = 1'b1;
        tick();
        ds_rfd = 1'b0;
        check("t2.rdy_drop", 64'(rd_rdy), 64'd0);

        // ---- 3. a stalled write holds its request stable -----------------
        wr_nd = 1'b1; wr_addr = 32'hABCD0; wr_data = 16'h5555;
        tick();
        wr_nd = 1'b0; wr_addr = 32'h0; wr_data = 16'h0;
        for (int i = 0; i < 5; i++) begin
            check_mem($sformatf("t3.stall%0d", i), 1'b1, 1'b1, 32'hABCD0, 16'h5555);
            check($sformatf("t3.rd_rfd%0d", i), 64'(rd_us_rfd), 64'd0);
            check($sformatf("t3.wr_rfd%0d", i), 64'(wr_us_rfd), 64'd0);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("t3.done_req", 64'(mem_req), 64'd0);
        // A stray rvalid outside WAIT_RD must not produce a return.
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_rvalid = 1'b0;
        check("t3.stray_rvalid", 64'(rd_rdy), 64'd0);

        // ---- 4. clear with the grant tied high ----------------------------
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        run_clear("t4");

        // ---- 5. clear requested while a read is outstanding ----------------
        rd_nd = 1'b1; rd_addr = 32'h40; rd_tag = 19'h3;
        tick();
        rd_nd = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("t5.busy",  64'(clear_busy), 64'd1);
        check("t5.req",   64'(mem_req),    64'd0);
        check("t5.rdy0",  64'(rd_rdy),     64'd0);
        mem_rvalid = 1'b1; mem_rdata = 16'h2222;
        tick();
        mem_rvalid = 1'b0;
        check("t5.rdy",     64'(rd_rdy),     64'd1);
        check("t5.data",    64'(rd_data),    64'h2222);
        check("t5.tag",     64'(rd_tag_out), 64'h3);
        check("t5.req_ret", 64'(mem_req),    64'd0);
        ds_rfd = 1'b1;
        tick();
        ds_rfd = 1'b0;
        check("t5.rdy_drop", 64'(rd_rdy), 64'd0);
        run_clear("t5");

        // ---- 6. reset mid-clear, then a fresh clear ----------------------
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        mem_gnt = 1'b1;
        tick(); tick();
        check("t6.cnt2", 64'(mem_addr), 64'd2);
        rst = 1'b0;
        #1;
        check("t6.rst_busy", 64'(clear_busy), 64'd0);
        check("t6.rst_req",  64'(mem_req),    64'd0);
        mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        check("t6.idle_busy", 64'(clear_busy), 64'd0);
        check("t6.idle_req",  64'(mem_req),    64'd0);
        check("t6.idle_rdy",  64'(rd_rdy),     64'd0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        run_clear("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/zbuf_mem_sched.md
Name: zbuf_mem_sched

Overview:
- Schedules the single z-buffer memory port between three sources:
  - depth-test reads, whose addresses come from the z-buffer address calculator;
  - depth-test writebacks;
  - a full-buffer clear engine.
- Sits between the address-calc / depth-test stages and the z-buffer memory controller.
- Serialises accesses, keeps each fragment's tag attached to its read data, and runs frame clears without losing accepted requests.

Parameters:
- ADDR_W, 32, z-buffer word address width.
- DATA_W, 16, depth word width (half-float).
- TAG_W, 19, fragment id width.
- CLEAR_WORDS, 307200, words written per clear (640x480).
- CLEAR_VAL, 16'h7BFF, depth value written by a clear (max finite half).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clear_req  in  1  one-cycle pulse; requests a buffer clear.
- clear_busy  out  1  high from the cycle after clear_req until the last clear write is granted.
- rd_nd  in  1  read request valid.
- rd_us_rfd  out  1  scheduler can accept a read.
- rd_addr  in  ADDR_W  read word address.
- rd_tag  in  TAG_W  fragment id travelling with the read.
- rd_rdy  out  1  read data valid.
- rd_data  out  DATA_W  returned depth.
- rd_tag_out  out  TAG_W  fragment id of rd_data.
- ds_rfd  in  1  downstream accepts rd_data.
- wr_nd  in  1  write request valid.
- wr_us_rfd  out  1  scheduler can accept a write.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  depth to write.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  read data valid; always arrives at least 1 cycle after the granting mem_gnt.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, clear counter 0, holding registers empty, any pending clear dropped.
- A reset mid-clear or mid-read abandons the operation; no rd_rdy is produced afterwards.
- States: IDLE, ISSUE, WAIT_RD, RET_RD, CLEAR.
- Input handshake:
  - rd_us_rfd and wr_us_rfd are high only in IDLE with no clear pending and no held request.
  - A request is accepted on the rising edge where nd & us_rfd.
  - Address, data and tag are captured into a one-entry holding register per source.
  - Reads and writes may be accepted in the same cycle.
- Issue order: pending clear > held write > held read. The write goes first so a read can never overtake a write.
- IDLE -> CLEAR when a clear is pending; IDLE -> ISSUE when either holding register is full.
- ISSUE:
  - mem_req=1, asserted the cycle after acceptance.
  - mem_addr / mem_we / mem_wdata are taken from the selected entry and held stable until mem_gnt.
  - On mem_gnt: write -> entry freed; next state is ISSUE if the read entry is full, else IDLE.
  - On mem_gnt: read -> WAIT_RD, mem_req=0.
- Only one read is outstanding at a time.
- WAIT_RD: on mem_rvalid, register mem_rdata and the held tag -> RET_RD. mem_req stays 0.
- RET_RD:
  - rd_rdy=1; rd_data and rd_tag_out are held until ds_rfd=1.
  - In the ds_rfd cycle rd_rdy is still 1; it drops the next cycle.
  - Next state IDLE, or CLEAR if a clear is pending.
- Clear:
  - clear_req in any state sets clear pending and raises clear_busy next cycle.
  - The in-flight transaction (including a read return) finishes first.
  - CLEAR drives mem_req=1, mem_we=1, mem_addr=counter, mem_wdata=CLEAR_VAL.
  - The counter increments on each mem_gnt.
  - On the grant with counter == CLEAR_WORDS-1: counter resets to 0, clear_busy drops the next cycle, state IDLE.
  - clear_req while already clearing or pending is ignored; it does not restart the clear.
- Width rules:
  - Clear counter is clog2(CLEAR_WORDS) bits, zero-extended to ADDR_W.
  - Held addresses are passed through unmodified.
- mem_rvalid outside WAIT_RD is ignored.

Test Plan:
1. Reset with rst=0 while mem_req would be high -> all outputs 0 immediately. Release, then rd_nd with addr 0x12C0, tag 0x00A1 -> mem_req next cycle, mem_we=0, mem_addr=0x12C0. mem_gnt, then mem_rvalid with data 0x3C00 two cycles later -> rd_rdy=1, rd_data=0x3C00, rd_tag_out=0x00A1 until ds_rfd.
2. Simultaneous wr_nd (addr 0x0005, data 0x3800) and rd_nd (addr 0x0005) -> write issued first with mem_we=1 and data 0x3800; read issued only after the write's mem_gnt.
3. mem_gnt held low 5 cycles during a write -> mem_req, mem_addr and mem_wdata stable all 5 cycles; rd_us_rfd and wr_us_rfd remain 0.
4. clear_req with CLEAR_WORDS overridden to 4 and mem_gnt tied high -> clear_busy next cycle; writes 0x7BFF to addresses 0,1,2,3 on consecutive cycles; clear_busy 0 after the last grant; us_rfd 0 throughout.
5. clear_req while in WAIT_RD -> the read completes and returns via rd_rdy first, then the clear runs; no request is lost.
6. rst pulsed low mid-clear at counter=2 -> clear aborted, clear_busy=0. A new clear_req restarts at address 0.
